// File: rtl/exe_dispatch_if.sv
// exe_dispatch_if: request, execution-unit and result signals of exe_dispatch.
// Carries o_err_count only when EXE_DISPATCH_ERRCNT_EN is defined.
interface exe_dispatch_if #(parameter int WIDTH = 32);
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_oper;
  logic [WIDTH-1:0] i_argA;
  logic [WIDTH-1:0] i_argB;
  logic [1:0]       o_exe_oper;
  logic [WIDTH-1:0] o_exe_argA;
  logic [WIDTH-1:0] o_exe_argB;
  logic [WIDTH-1:0] i_exe_result;
  logic             i_exe_carry;
  logic             i_exe_error;
  logic             o_valid;
  logic             i_ready;
  logic [1:0]       o_oper;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
  logic             o_error;
`ifdef EXE_DISPATCH_ERRCNT_EN
  logic [7:0]       o_err_count;
`endif
  modport slave (
    input  i_valid, i_oper, i_argA, i_argB, i_exe_result, i_exe_carry, i_exe_error, i_ready,
`ifdef EXE_DISPATCH_ERRCNT_EN
    output o_err_count,
`endif
    output o_ready, o_exe_oper, o_exe_argA, o_exe_argB, o_valid, o_oper, o_result, o_carry, o_error
  );
  modport master (
    output i_valid, i_oper, i_argA, i_argB, i_exe_result, i_exe_carry, i_exe_error, i_ready,
`ifdef EXE_DISPATCH_ERRCNT_EN
    input  o_err_count,
`endif
    input  o_ready, o_exe_oper, o_exe_argA, o_exe_argB, o_valid, o_oper, o_result, o_carry, o_error
  );
endinterface

// File: rtl/exe_dispatch.sv
// exe_dispatch: FIFO-buffered operand dispatch and result capture around an execution unit.
// Optional error counter output enabled by EXE_DISPATCH_ERRCNT_EN.
module exe_dispatch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic            i_clk,
  input logic            i_rst_n,
  exe_dispatch_if.slave  io
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t           state_q, state_d;
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic             full, empty, push, pop;
  logic [1:0]       exe_oper_q, exe_oper_d, oper_q, oper_d;
  logic [WIDTH-1:0] exe_a_q, exe_a_d, exe_b_q, exe_b_d, result_q, result_d;
  logic             valid_q, valid_d, carry_q, carry_d, error_q, error_d;
  // Extra wrap bit distinguishes full from empty when the indices match.
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = wr_q == rd_q;
  assign push  = io.i_valid && !full;
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    valid_d  = valid_q;
    oper_d   = oper_q;
    result_d = result_q;
    carry_d  = carry_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        pop     = !empty;
        state_d = empty ? IDLE : EXEC;
      end
      EXEC: begin
        valid_d  = 1'b1;
        oper_d   = exe_oper_q;
        result_d = io.i_exe_result;
        carry_d  = (exe_oper_q == 2'd0) && io.i_exe_carry;
        error_d  = exe_oper_q[1] && io.i_exe_error;
        state_d  = DONE;
      end
      DONE: if (io.i_ready) begin
        valid_d = 1'b0;
        pop     = !empty;
        state_d = empty ? IDLE : EXEC;
      end
      default: state_d = IDLE;
    endcase
    {exe_oper_d, exe_a_d, exe_b_d} = pop ? mem_q[rd_q[AW-1:0]] : {exe_oper_q, exe_a_q, exe_b_q};
    wr_d = wr_q + {{AW{1'b0}}, push};
    rd_d = rd_q + {{AW{1'b0}}, pop};
  end
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {io.i_oper, io.i_argA, io.i_argB};
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      exe_oper_q <= '0;
      exe_a_q    <= '0;
      exe_b_q    <= '0;
      valid_q    <= 1'b0;
      oper_q     <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      exe_oper_q <= exe_oper_d;
      exe_a_q    <= exe_a_d;
      exe_b_q    <= exe_b_d;
      valid_q    <= valid_d;
      oper_q     <= oper_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      error_q    <= error_d;
    end
  end
`ifdef EXE_DISPATCH_ERRCNT_EN
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == EXEC && error_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign io.o_err_count = cnt_q;
`endif
  assign io.o_ready    = !full;
  assign io.o_exe_oper = exe_oper_q;
  assign io.o_exe_argA = exe_a_q;
  assign io.o_exe_argB = exe_b_q;
  assign io.o_valid    = valid_q;
  assign io.o_oper     = oper_q;
  assign io.o_result   = result_q;
  assign io.o_carry    = carry_q;
  assign io.o_error    = error_q;
endmodule

// File: tb/tb_exe_dispatch.sv
// tb_exe_dispatch: directed bench with a request-order scoreboard and an execution-unit model.
module tb_exe_dispatch;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int errs_seen = 0;
  logic [35:0] q[$];
  exe_dispatch_if #(.WIDTH(32)) io ();
  exe_dispatch #(.WIDTH(32), .DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst_n(rst_n), .io(io.slave));
  always #5 clk = ~clk;
  // Execution unit: error mirrors argA[0]; carry is argB[0] for non-add ops so sanitising is visible.
  function automatic logic [33:0] exe(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      2'd0:    return {a[0], s[32], s[31:0]};
      2'd1:    return {a[0], b[0], 31'b0, a < b};
      2'd2:    return {a[0], b[0], b};
      default: return {a[0], b[0], ~a};
    endcase
  endfunction
  function automatic logic [35:0] exp_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] r;
    r = exe(op, a, b);
    return {op, r[31:0], r[32] & (op == 2'd0), r[33] & op[1]};
  endfunction
  logic [33:0] exe_out;
  assign exe_out         = exe(io.o_exe_oper, io.o_exe_argA, io.o_exe_argB);
  assign io.i_exe_result = exe_out[31:0];
  assign io.i_exe_carry  = exe_out[32];
  assign io.i_exe_error  = exe_out[33];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (io.o_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_result: got %0h want none", {io.o_oper, io.o_result, io.o_carry, io.o_error});
        end else if ({io.o_oper, io.o_result, io.o_carry, io.o_error} !== q[0]) begin
          errors++;
          $display("FAIL result_payload: got %0h want %0h", {io.o_oper, io.o_result, io.o_carry, io.o_error}, q[0]);
        end
        if (io.i_ready && q.size() != 0) begin
          errs_seen += int'(q[0][0]);
          void'(q.pop_front());
        end
      end
      if (io.i_valid && io.o_ready) q.push_back(exp_of(io.i_oper, io.i_argA, io.i_argB));
    end
  end
  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    io.i_valid = 1'b1;
    io.i_oper  = op;
    io.i_argA  = a;
    io.i_argB  = b;
    @(negedge clk);
    while (!io.o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1 io.i_valid = 1'b0;
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!io.o_valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 200) chk("valid_timeout", 64'(n), 64'(0));
  endtask
  task automatic take(input string nm, input logic [35:0] exp);
    wait_valid();
    chk(nm, {io.o_oper, io.o_result, io.o_carry, io.o_error}, 64'(exp));
    io.i_ready = 1'b1;
    @(posedge clk);
    #1 io.i_ready = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    io.i_ready = 1'b1;
    while ((q.size() != 0 || io.o_valid) && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_done", 64'(q.size() != 0 || io.o_valid), 64'(0));
  endtask
  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, 64'(io.o_ready), 64'(1));
    chk({nm, "_valid"}, 64'(io.o_valid), 64'(0));
    chk({nm, "_result"}, {io.o_oper, io.o_result, io.o_carry, io.o_error}, 64'(0));
    chk({nm, "_exe"}, {io.o_exe_oper, io.o_exe_argA, io.o_exe_argB}, 64'(0));
`ifdef EXE_DISPATCH_ERRCNT_EN
    chk({nm, "_errcnt"}, 64'(io.o_err_count), 64'(0));
`endif
  endtask
  initial begin
    int accepts;
    logic acc;
    logic [35:0] snap;
    logic [31:0] snap_a;
    io.i_valid = 1'b0;
    io.i_oper  = '0;
    io.i_argA  = '0;
    io.i_argB  = '0;
    io.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Single add: accept at E0, issue at E1, valid after E2.
    io.i_ready = 1'b1;
    io.i_valid = 1'b1;
    io.i_oper  = 2'd0;
    io.i_argA  = 32'hFFFF_FFFF;
    io.i_argB  = 32'h1;
    @(posedge clk);
    #1 io.i_valid = 1'b0;
    chk("lat_e0_valid", 64'(io.o_valid), 64'(0));
    @(posedge clk);
    #1 chk("lat_e1_exe", {io.o_exe_oper, io.o_exe_argA, io.o_exe_argB}, {30'b0, 2'd0, 32'hFFFF_FFFF, 32'h1});
    chk("lat_e1_valid", 64'(io.o_valid), 64'(0));
    @(posedge clk);
    #1 chk("lat_e2_valid", 64'(io.o_valid), 64'(1));
    chk("add_payload", {io.o_oper, io.o_result, io.o_carry, io.o_error}, {28'b0, 2'd0, 32'h0, 1'b1, 1'b0});
    drain();
    io.i_ready = 1'b0;
    // Flag sanitising with raw carry and error both set where possible.
    push(2'd1, 32'd3, 32'd5);
    take("cmp_flags", {2'd1, 32'd1, 1'b0, 1'b0});
    push(2'd3, 32'd1, 32'd1);
    take("cvt_flags", {2'd3, 32'hFFFF_FFFE, 1'b0, 1'b1});
    push(2'd2, 32'd5, 32'd7);
    take("set_flags", {2'd2, 32'd7, 1'b0, 1'b1});
    push(2'd0, 32'h8000_0000, 32'h8000_0003);
    take("add_carry", {2'd0, 32'd3, 1'b1, 1'b0});
    // Full FIFO with downstream stalled.
    accepts = 0;
    io.i_valid = 1'b1;
    io.i_oper  = 2'd0;
    io.i_argA  = 32'h0F0F_0000;
    io.i_argB  = 32'h1234_5678;
    repeat (12) begin
      @(negedge clk);
      acc = io.i_valid && io.o_ready;
      @(posedge clk);
      #1 if (acc) begin
        accepts++;
        io.i_oper = 2'(accepts);
        io.i_argA = 32'h0F0F_0000 + 32'(accepts);
        io.i_argB = 32'h1234_5678 ^ 32'(accepts * 3);
      end
    end
    chk("full_accepts", 64'(accepts), 64'(DEPTH + 1));
    chk("full_ready_low", 64'(io.o_ready), 64'(0));
    io.i_ready = 1'b1;
    for (int n = 0; n < 200 && accepts < DEPTH + 2; n++) begin
      @(negedge clk);
      acc = io.i_valid && io.o_ready;
      @(posedge clk);
      #1 if (acc) begin
        accepts++;
        io.i_valid = 1'b0;
      end
    end
    chk("full_extra_accepted", 64'(accepts), 64'(DEPTH + 2));
    drain();
    io.i_ready = 1'b0;
    // Backpressure: payload and issued operands hold while stalled.
    push(2'd0, 32'h8000_0000, 32'h8000_0001);
    push(2'd2, 32'd6, 32'd9);
    wait_valid();
    snap   = {io.o_oper, io.o_result, io.o_carry, io.o_error};
    snap_a = io.o_exe_argA;
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", {io.o_valid, io.o_oper, io.o_result, io.o_carry, io.o_error, io.o_exe_argA}, {1'b1, snap, snap_a});
    end
    chk("bp_literal", 64'(snap), {28'b0, 2'd0, 32'h1, 1'b1, 1'b0});
    @(posedge clk);
    #1 io.i_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_pop_at_ready", 64'(io.o_exe_argA), 64'(6));
    drain();
    io.i_ready = 1'b0;
    // Reset with one result held and three queued.
    push(2'd0, 32'd10, 32'd20);
    push(2'd1, 32'd11, 32'd21);
    push(2'd2, 32'd12, 32'd22);
    push(2'd3, 32'd13, 32'd23);
    wait_valid();
    chk("pre_reset_valid", 64'(io.o_valid), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    q.delete();
    errs_seen = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    io.i_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_no_stale", 64'(io.o_valid), 64'(0));
    end
`ifdef EXE_DISPATCH_ERRCNT_EN
    push(2'd3, 32'd1, 32'd0);
    push(2'd1, 32'd1, 32'd0);
    drain();
    chk("errcnt_one", 64'(io.o_err_count), 64'(1));
    for (int i = 0; i < 300; i++) push(2'd2, 32'd1, 32'(i));
    drain();
    chk("errcnt_model", 64'(errs_seen), 64'(301));
    chk("errcnt_sat", 64'(io.o_err_count), 64'(255));
    repeat (4) @(posedge clk);
    #1 chk("errcnt_hold", 64'(io.o_err_count), 64'(255));
`endif
    push(2'd0, 32'd100, 32'd23);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
